// File: rtl/hex_scroll_ctrl.sv
// Scrolls a 6-digit window across the 8 nibbles of a 32-bit word on the HEX0..HEX5 displays.
// The window advances once every to_speed_export millisecond ticks.
module hex_scroll_ctrl #(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] to_hex_export,
    input  logic [9:0]  to_speed_export,
    input  logic        enable,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [2:0]  offset,
    output logic        step_pulse,
    output logic        busy
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [31:0]    r_dataLat;
    logic [2:0]     r_offset;
    logic [9:0]     r_speedLat;
    logic [9:0]     r_stepCnt;
    logic [TW-1:0]  r_tickCnt;
    logic           r_stepPulse;
    logic [6:0]     r_hex [6];
    logic [2:0]     w_digitIdx [6];

    logic w_go;
    logic w_change;
    logic w_tick;
    logic w_stepDue;
    logic w_step;
    logic w_latchSpeed;

    function automatic logic [6:0] segDecode(input logic [3:0] nib);
        case (nib)
            4'h0: segDecode = 7'h40;
            4'h1: segDecode = 7'h79;
            4'h2: segDecode = 7'h24;
            4'h3: segDecode = 7'h30;
            4'h4: segDecode = 7'h19;
            4'h5: segDecode = 7'h12;
            4'h6: segDecode = 7'h02;
            4'h7: segDecode = 7'h78;
            4'h8: segDecode = 7'h00;
            4'h9: segDecode = 7'h10;
            4'hA: segDecode = 7'h08;
            4'hB: segDecode = 7'h03;
            4'hC: segDecode = 7'h46;
            4'hD: segDecode = 7'h21;
            4'hE: segDecode = 7'h06;
            default: segDecode = 7'h0E;
        endcase
    endfunction

    // A new display word always wins: it preempts both a due step and a drop to HOLD.
    always_comb begin
        w_go         = enable && (to_speed_export != 10'd0);
        w_change     = (r_state != LOAD) && (to_hex_export != r_dataLat);
        w_tick       = (r_state == RUN) && (r_tickCnt == TICK_MAX);
        w_stepDue    = w_tick && (r_stepCnt == r_speedLat - 10'd1);
        w_nextState  = r_state;
        w_latchSpeed = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            HOLD: begin
                if (w_change) begin
                    w_nextState = LOAD;
                end else if (w_go) begin
                    w_nextState  = RUN;
                    w_latchSpeed = 1'b1;
                end
            end
            RUN: begin
                if (w_change) begin
                    w_nextState = LOAD;
                end else if (!w_go) begin
                    w_nextState = HOLD;
                end else if (w_stepDue) begin
                    w_step       = 1'b1;
                    w_latchSpeed = 1'b1;
                end
            end
            LOAD: begin
                if (w_go) begin
                    w_nextState  = RUN;
                    w_latchSpeed = 1'b1;
                end else begin
                    w_nextState = HOLD;
                end
            end
            default: w_nextState = HOLD;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            w_digitIdx[k] = r_offset + 3'(k);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state     <= HOLD;
            r_dataLat   <= 32'd0;
            r_offset    <= 3'd0;
            r_speedLat  <= 10'd0;
            r_stepCnt   <= 10'd0;
            r_tickCnt   <= '0;
            r_stepPulse <= 1'b0;
            for (int k = 0; k < 6; k++) begin
                r_hex[k] <= 7'h7F;
            end
        end else begin
            r_state     <= w_nextState;
            r_stepPulse <= w_step;
            if (w_latchSpeed) begin
                r_speedLat <= to_speed_export;
            end
            // Prescaler and step counter only run in RUN; elsewhere they sit at zero.
            if (r_state == RUN) begin
                r_tickCnt <= w_tick ? '0 : r_tickCnt + 1'b1;
                if (w_tick) begin
                    r_stepCnt <= w_stepDue ? 10'd0 : r_stepCnt + 10'd1;
                end
            end else begin
                r_tickCnt <= '0;
                r_stepCnt <= 10'd0;
            end
            if (r_state == LOAD) begin
                r_dataLat <= to_hex_export;
                r_offset  <= 3'd0;
            end else if (w_step) begin
                r_offset <= r_offset + 3'd1;
            end
            for (int k = 0; k < 6; k++) begin
                r_hex[k] <= segDecode(r_dataLat[{w_digitIdx[k], 2'b00} +: 4]);
            end
        end
    end

    assign hex0       = r_hex[0];
    assign hex1       = r_hex[1];
    assign hex2       = r_hex[2];
    assign hex3       = r_hex[3];
    assign hex4       = r_hex[4];
    assign hex5       = r_hex[5];
    assign offset     = r_offset;
    assign step_pulse = r_stepPulse;
    assign busy       = (r_state == RUN);

endmodule
